muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//   Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU and the HI/LO register pair.
//   Accepts an op code from the control unit's ALU_Control field and runs an iterative
//   shift-add multiply or restoring divide, one bit per cycle. Holds busy to stall the
//   pipeline (including MFHI/MFLO) and commits HI/LO atomically on completion.
// PARAMETERS
//   WIDTH   32             operand width; HI/LO each WIDTH bits
//   CNT_W   $clog2(WIDTH)  iteration counter width (derived, not overridden)
// PORTS
//   clk        in   1      system clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      request; sampled only in IDLE
//   op         in   5      ALU_Control code: `MUL, `MULU, `DIV or `DIVU (from defines.v)
//   src_a      in   WIDTH  multiplicand / dividend (rs)
//   src_b      in   WIDTH  multiplier / divisor (rt)
//   cancel     in   1      abort in-flight op (pipeline flush)
//   busy       out  1      high from accepting edge until done cycle inclusive; stall
//   done       out  1      one-cycle pulse; hi/lo hold the new result this cycle
//   div_zero   out  1      valid with done; high if DIV/DIVU with src_b == 0
//   hi         out  WIDTH  HI register (MFHI source)
//   lo         out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, div_zero, counter = 0; hi = lo = 0. Reset mid-op
//     drops the operation entirely; nothing is committed.
//   Accept: start=1 in IDLE with op in {MUL,MULU,DIV,DIVU} -> latch operands, op, signs;
//     other op codes ignored (state stays IDLE). start outside IDLE ignored.
//   Signed ops (MUL, DIV): operands converted to magnitudes at accept; sign_a, sign_b saved.
//   FSM: IDLE -> RUN (accept) -> FIX (after WIDTH iterations) -> DONE -> IDLE.
//     RUN: counter 0..WIDTH-1, one step per cycle.
//       MUL: 2*WIDTH accumulator, add multiplicand if LSB of multiplier, shift right.
//       DIV: restoring step; remainder = {rem,q_msb} - divisor, keep if non-negative.
//     FIX: one cycle; MUL: negate 64-bit product if sign_a^sign_b.
//       DIV: negate quotient if sign_a^sign_b; negate remainder if sign_a.
//     DONE: hi/lo written (MUL: hi=prod[2W-1:W], lo=prod[W-1:0]; DIV: hi=rem, lo=quot);
//       done=1 for exactly this cycle; busy still 1; next edge -> IDLE, busy=0.
//   Latency: fixed WIDTH+2 cycles from accepting edge to done cycle (34 for WIDTH=32),
//     independent of operand values. Back-to-back: earliest next accept is the cycle
//     after done (one IDLE cycle).
//   Divide by zero: iterations still run (latency unchanged); at DONE lo = all ones,
//     hi = original src_a (sign-correct, not magnitude); div_zero=1 with done.
//   Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0 (falls out of
//     magnitude math; no special case, no flag).
//   cancel: in RUN or FIX -> IDLE on next edge, busy=0, hi/lo unchanged, no done.
//     cancel in DONE cycle ignored (commit already made). cancel with start in IDLE:
//     cancel wins, nothing accepted.
//   hi/lo change only in DONE or reset; reads during busy see old values (caller stalls).
// STRUCTURE
//   defines.v: op codes `MUL/`MULU/`DIV/`DIVU (existing) plus state encodings
//     `MD_IDLE, `MD_RUN, `MD_FIX, `MD_DONE (2 bits).
//   Sub-module muldiv_step: combinational single-iteration datapath (mul add-shift or
//     div subtract-restore, selected by is_div); FSM, counter, sign fix, HI/LO here.
// TESTING
//   MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> done at +34, hi=0xFFFF_FFFE, lo=0x0000_0001.
//   MULT -3*7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; busy high all 34 cycles.
//   DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIVU 100/7 -> lo=14, hi=2.
//   DIVU 5/0 -> lo=0xFFFF_FFFF, hi=5, div_zero=1 with done; DIV 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
//   start during RUN and op=`ADD in IDLE -> ignored; cancel at RUN cycle 10 -> busy=0 next edge, hi/lo unchanged, no done.
//   reset_n low mid-RUN -> all outputs 0 immediately; new MULTU 2*3 after release -> lo=6, hi=0.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// ============================================================================
// Module  : muldiv_seq_pkg
// Brief   : ALU_Control op codes and sequencer state encodings for muldiv_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_seq_pkg;

   typedef logic [4:0] alu_op_t;

   localparam alu_op_t OP_ADD  = 5'd2;
   localparam alu_op_t OP_MUL  = 5'd12;
   localparam alu_op_t OP_MULU = 5'd13;
   localparam alu_op_t OP_DIV  = 5'd14;
   localparam alu_op_t OP_DIVU = 5'd15;

   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_RUN  = 2'd1;
   localparam logic [1:0] MD_FIX  = 2'd2;
   localparam logic [1:0] MD_DONE = 2'd3;

   function automatic logic is_muldiv_op(input alu_op_t op);
      return (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq_if.sv
// ============================================================================
// Module  : muldiv_seq_if
// Brief   : Request/result bundle between the control unit and muldiv_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_seq_if
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
) ();

   logic             start;
   alu_op_t          op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, cancel,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, cancel,
      output busy, done, div_zero, hi, lo
   );

endinterface

`default_nettype wire

// File: rtl/muldiv_seq_step.sv
// ============================================================================
// Module  : muldiv_seq_step
// Brief   : One iteration of shift-add multiply or restoring divide on {hi,lo} acc.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq_step #(
   parameter int WIDTH = 32
) (
   input  wire logic                 i_is_div,
   input  wire logic [2*WIDTH-1:0]   i_acc,
   input  wire logic [WIDTH-1:0]     i_opnd,
   output logic      [2*WIDTH-1:0]   o_acc
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
   assign w_shift = i_acc[2*WIDTH-1:WIDTH-1];
   assign w_diff  = w_shift - {1'b0, i_opnd};

   // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
   assign o_acc = i_is_div
                ? (w_diff[WIDTH] ? {w_shift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0}
                                 : {w_diff[WIDTH-1:0],  i_acc[WIDTH-2:0], 1'b1})
                : {w_sum, i_acc[WIDTH-1:1]};

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module  : muldiv_seq
// Brief   : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  wire logic   clk,
   input  wire logic   reset_n,
   muldiv_seq_if.slave bus
);

   localparam int                CNT_W  = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opnd;
   logic                 r_is_div;
   logic                 r_sign_a;
   logic                 r_sign_b;
   logic                 r_dz;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   logic                 w_accept;
   logic                 w_is_div;
   logic                 w_signed;
   logic                 w_sign_a;
   logic                 w_sign_b;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic                 w_neg_q;
   logic                 w_dz;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quot;
   logic [WIDTH-1:0]     w_rem;
   logic [WIDTH-1:0]     w_fix_hi;
   logic [WIDTH-1:0]     w_fix_lo;

   assign w_accept = bus.start && !bus.cancel && (r_state == MD_IDLE) && is_muldiv_op(bus.op);
   assign w_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   assign w_signed = (bus.op == OP_MUL) || (bus.op == OP_DIV);
   assign w_sign_a = w_signed && bus.src_a[WIDTH-1];
   assign w_sign_b = w_signed && bus.src_b[WIDTH-1];
   assign w_mag_a  = w_sign_a ? -bus.src_a : bus.src_a;
   assign w_mag_b  = w_sign_b ? -bus.src_b : bus.src_b;

   muldiv_seq_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_opnd   (r_opnd),
      .o_acc    (w_acc_next)
   );

   // A zero divisor leaves the untouched dividend magnitude in the remainder,
   // so the normal remainder sign fix already yields the original src_a for HI.
   assign w_neg_q  = r_sign_a ^ r_sign_b;
   assign w_dz     = r_is_div && (r_opnd == '0);
   assign w_prod   = w_neg_q ? -r_acc : r_acc;
   assign w_quot   = w_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem    = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
   assign w_fix_lo = r_is_div ? (w_dz ? '1 : w_quot) : w_prod[WIDTH-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= MD_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_dz     <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (w_accept) begin
                  r_state  <= MD_RUN;
                  r_cnt    <= '0;
                  r_is_div <= w_is_div;
                  r_sign_a <= w_sign_a;
                  r_sign_b <= w_sign_b;
                  r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
                  r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
               end
            end
            MD_RUN: begin
               if (bus.cancel) begin
                  r_state <= MD_IDLE;
               end else begin
                  r_acc <= w_acc_next;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == C_LAST) begin
                     r_state <= MD_FIX;
                  end
               end
            end
            MD_FIX: begin
               if (bus.cancel) begin
                  r_state <= MD_IDLE;
               end else begin
                  r_hi    <= w_fix_hi;
                  r_lo    <= w_fix_lo;
                  r_dz    <= w_dz;
                  r_state <= MD_DONE;
               end
            end
            MD_DONE: begin
               r_dz    <= 1'b0;
               r_state <= MD_IDLE;
            end
            default: begin
               r_state <= MD_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = (r_state != MD_IDLE);
   assign bus.done     = (r_state == MD_DONE);
   assign bus.div_zero = (r_state == MD_DONE) && r_dz;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module  : tb_muldiv_seq
// Brief   : Directed self-checking bench for muldiv_seq against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   localparam int LAT = 34;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_seq_if #(.WIDTH(32)) bus ();

   muldiv_seq #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Result as {div_zero, hi, lo} straight from MIPS arithmetic rules.
   function automatic logic [64:0] model_res(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint p;
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] up;
      logic [64:0] res;
      res = '0;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      if (op == OP_MUL) begin
         p   = sa * sb;
         res = {1'b0, p[63:0]};
      end else if (op == OP_MULU) begin
         up  = {32'd0, a} * {32'd0, b};
         res = {1'b0, up};
      end else if (b == 32'd0) begin
         res = {1'b1, a, 32'hFFFF_FFFF};
      end else if (op == OP_DIV) begin
         q   = sa / sb;
         r   = sa % sb;
         res = {1'b0, r[31:0], q[31:0]};
      end else begin
         res = {1'b0, a % b, a / b};
      end
      return res;
   endfunction

   int          m_cnt  = 0;
   logic [31:0] m_hi   = '0;
   logic [31:0] m_lo   = '0;
   logic        m_dz   = 1'b0;
   logic [64:0] m_pend = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt <= 0;
         m_hi  <= '0;
         m_lo  <= '0;
         m_dz  <= 1'b0;
      end else if (m_cnt == 0) begin
         if (bus.start && !bus.cancel &&
             (bus.op == OP_MUL || bus.op == OP_MULU || bus.op == OP_DIV || bus.op == OP_DIVU)) begin
            m_cnt  <= 1;
            m_pend <= model_res(bus.op, bus.src_a, bus.src_b);
         end
      end else if (m_cnt == LAT) begin
         m_cnt <= 0;
      end else if (bus.cancel) begin
         m_cnt <= 0;
      end else if (m_cnt == LAT - 1) begin
         m_cnt <= LAT;
         {m_dz, m_hi, m_lo} <= m_pend;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      chk("cmp busy",     64'(bus.busy),     64'(m_cnt != 0));
      chk("cmp done",     64'(bus.done),     64'(m_cnt == LAT));
      chk("cmp div_zero", 64'(bus.div_zero), 64'((m_cnt == LAT) && m_dz));
      chk("cmp hi",       64'(bus.hi),       64'(m_hi));
      chk("cmp lo",       64'(bus.lo),       64'(m_lo));
   end

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      @(posedge clk); #2;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 1;
      @(negedge clk);
      while (!bus.done && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz);
      int n;
      issue(op, a, b);
      wait_done(n);
      chk({name, " latency"}, 64'(n), 64'(LAT));
      chk({name, " hi"}, 64'(bus.hi), 64'(ehi));
      chk({name, " lo"}, 64'(bus.lo), 64'(elo));
      chk({name, " div_zero"}, 64'(bus.div_zero), 64'(edz));
      @(posedge clk); #2;
   endtask

   initial begin
      int n;
      bus.start  = 1'b0;
      bus.op     = '0;
      bus.src_a  = '0;
      bus.src_b  = '0;
      bus.cancel = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);
      chk("reset hi",   64'(bus.hi),   64'd0);
      chk("reset lo",   64'(bus.lo),   64'd0);
      reset_n = 1'b1;
      @(posedge clk); #2;

      run_op("multu max",   OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("mult -3*7",   OP_MUL,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("mult min*min",OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_op("div -7/2",    OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div 7/-2",    OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      run_op("divu 100/7",  OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
      run_op("divu 5/0",    OP_DIVU, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
      run_op("div -20/0",   OP_DIV,  32'hFFFF_FFEC, 32'd0,         32'hFFFF_FFEC, 32'hFFFF_FFFF, 1'b1);
      run_op("div ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

      // A second request while running must not disturb the first.
      issue(OP_MULU, 32'd6, 32'd7);
      repeat (5) @(posedge clk);
      #2;
      bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd9; bus.src_b = 32'd3;
      @(posedge clk); #2;
      bus.start = 1'b0;
      wait_done(n);
      chk("start in run hi", 64'(bus.hi), 64'd0);
      chk("start in run lo", 64'(bus.lo), 64'd42);
      @(posedge clk); #2;

      bus.start = 1'b1; bus.op = OP_ADD; bus.src_a = 32'd1; bus.src_b = 32'd1;
      @(posedge clk); #2;
      bus.start = 1'b0;
      chk("add ignored busy", 64'(bus.busy), 64'd0);

      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULU;
      @(posedge clk); #2;
      bus.start = 1'b0; bus.cancel = 1'b0;
      chk("cancel+start busy", 64'(bus.busy), 64'd0);

      issue(OP_MULU, 32'd2, 32'd2);
      repeat (9) @(posedge clk);
      #2;
      bus.cancel = 1'b1;
      @(posedge clk); #2;
      bus.cancel = 1'b0;
      chk("cancel busy", 64'(bus.busy), 64'd0);
      repeat (40) @(posedge clk);
      #2;
      chk("cancel hi kept", 64'(bus.hi), 64'd0);
      chk("cancel lo kept", 64'(bus.lo), 64'd42);

      issue(OP_MULU, 32'h0000_1234, 32'h10);
      repeat (5) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst busy", 64'(bus.busy), 64'd0);
      chk("midrst done", 64'(bus.done), 64'd0);
      chk("midrst dz",   64'(bus.div_zero), 64'd0);
      chk("midrst lo",   64'(bus.lo), 64'd0);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk); #2;
      run_op("multu 2*3", OP_MULU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
